goertzel_scheduler: RTL

- Sequences a bank of NUM_BINS GoertzelPower units, one per candidate frequency bin, all fed from the same sample stream.
- Issues a common start, collects each unit's done/power result, reduces them to a peak bin and peak power, and flags detection against a threshold.
- Triggers are periodic (interval counter) or one-shot; a watchdog aborts hung measurements.
- Sits between the DSP bank and the receiver's host/display logic.

---
 rtl/goertzel_scheduler.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/goertzel_scheduler.sv
// Goertzel bank scheduler: issues a common start to NUM_BINS Goertzel units,
// collects each unit's first done/power pair, reduces them to a peak bin and
// power, and flags detection against a threshold sampled at start time.
// Measurements are one-shot (single_i) or periodic (enable_i + interval_i).
// A watchdog aborts measurements whose units never all report.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   enable_i        periodic measurement enable
//   single_i        one-shot trigger, honoured only while idle
//   interval_i      minimum cycles between consecutive starts
//   threshold_i     detection threshold, sampled in the start cycle
//   start_o         one-cycle start pulse to every unit
//   done_i/power_i  per-unit done pulse and packed power (bin k at [k*PW +: PW])
//   busy_o          measurement in progress
//   result_valid_o  one-cycle strobe; peak_power_o/peak_bin_o/detect_o valid
//   timeout_o       one-cycle pulse on watchdog abort
//   overrun_o       one-cycle pulse when the interval elapses mid-measurement
module goertzel_scheduler #(
  parameter  int unsigned NUM_BINS       = 4,
  parameter  int unsigned PW             = 32,
  parameter  int unsigned IW             = 24,
  parameter  int unsigned TIMEOUT_CYCLES = 1048576,
  localparam int unsigned BIN_W          = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_i,
  input  logic                   single_i,
  input  logic [IW-1:0]          interval_i,
  input  logic [PW-1:0]          threshold_i,
  output logic [NUM_BINS-1:0]    start_o,
  input  logic [NUM_BINS-1:0]    done_i,
  input  logic [NUM_BINS*PW-1:0] power_i,
  output logic                   busy_o,
  output logic                   result_valid_o,
  output logic [PW-1:0]          peak_power_o,
  output logic [BIN_W-1:0]       peak_bin_o,
  output logic                   detect_o,
  output logic                   timeout_o,
  output logic                   overrun_o
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_REDUCE,
    S_REPORT
  } state_t;

  state_t              state;
  logic [IW-1:0]       cnt;
  logic [WD_W-1:0]     wd;
  logic [NUM_BINS-1:0] mask;
  logic [PW-1:0]       cap [NUM_BINS];
  logic [PW-1:0]       thr;
  logic [BIN_W-1:0]    red_idx;
  logic [PW-1:0]       run_pw;
  logic [BIN_W-1:0]    run_bin;
  logic                ovr_seen;

  logic [IW-1:0]       cnt_inc;
  logic                expired;
  logic [NUM_BINS-1:0] mask_nxt;
  logic [PW-1:0]       cur_pw;
  logic                take;
  logic [PW-1:0]       best_pw;
  logic [BIN_W-1:0]    best_bin;

  // Expiry is judged on the count the register holds next cycle, so that
  // periodic start pulses land exactly interval_i cycles apart.
  always_comb begin
    cnt_inc  = (&cnt) ? cnt : cnt + IW'(1);
    expired  = (cnt_inc >= interval_i);
    mask_nxt = mask | done_i;
    cur_pw   = cap[red_idx];
    // Bin 0 seeds the running peak; later bins replace it only when strictly larger.
    take     = (red_idx == '0) || (cur_pw > run_pw);
    best_pw  = take ? cur_pw : run_pw;
    best_bin = take ? red_idx : run_bin;
  end

  // Measurement sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      wd             <= '0;
      mask           <= '0;
      thr            <= '0;
      red_idx        <= '0;
      run_pw         <= '0;
      run_bin        <= '0;
      ovr_seen       <= 1'b0;
      start_o        <= '0;
      busy_o         <= 1'b0;
      result_valid_o <= 1'b0;
      peak_power_o   <= '0;
      peak_bin_o     <= '0;
      detect_o       <= 1'b0;
      timeout_o      <= 1'b0;
      overrun_o      <= 1'b0;
      for (int k = 0; k < NUM_BINS; k++) cap[k] <= '0;
    end else begin
      start_o        <= '0;
      result_valid_o <= 1'b0;
      timeout_o      <= 1'b0;
      overrun_o      <= 1'b0;
      cnt            <= cnt_inc;

      // One overrun pulse per measurement, only while periodic mode is on.
      if ((state != S_IDLE) && enable_i && expired && !ovr_seen) begin
        overrun_o <= 1'b1;
        ovr_seen  <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (single_i || (enable_i && expired)) begin
            state    <= S_START;
            start_o  <= '1;
            busy_o   <= 1'b1;
            cnt      <= '0;
            ovr_seen <= 1'b0;
          end
        end

        S_START: begin
          mask  <= '0;
          thr   <= threshold_i;
          wd    <= '0;
          state <= S_WAIT;
        end

        S_WAIT: begin
          // First done per bin wins; repeats on masked bins are dropped.
          for (int k = 0; k < NUM_BINS; k++) begin
            if (done_i[k] && !mask[k]) cap[k] <= power_i[k*PW +: PW];
          end
          mask <= mask_nxt;
          wd   <= wd + WD_W'(1);
          if (&mask_nxt) begin
            state   <= S_REDUCE;
            red_idx <= '0;
          end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state     <= S_IDLE;
            busy_o    <= 1'b0;
            timeout_o <= 1'b1;
          end
        end

        S_REDUCE: begin
          run_pw  <= best_pw;
          run_bin <= best_bin;
          red_idx <= red_idx + BIN_W'(1);
          // Final bin: publish the result on the edge entering REPORT.
          if (red_idx == BIN_W'(NUM_BINS - 1)) begin
            state          <= S_REPORT;
            peak_power_o   <= best_pw;
            peak_bin_o     <= best_bin;
            detect_o       <= (best_pw >= thr);
            result_valid_o <= 1'b1;
          end
        end

        S_REPORT: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end

        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
